uart_rx_gen2: RTL
=================

UART_RX_GEN2 -- requirements
Module: uart_rx_gen2

Interface
REQ-001 Parameter DATA_W, default 8, data bits per character; legal range 5..9.
REQ-002 Parameter OVS, default 16, BAUD_TICK pulses per bit; legal values 8 or 16.
REQ-003 Parameter FIFO_DEPTH, default 16, RX FIFO entries; power of two, 4..256.
REQ-004 Parameter TIMEOUT_BITS, default 32, idle bit periods before TIMEOUT asserts.
REQ-005 The clock SHALL be CLK (in, 1); reset SHALL be RESET_N (in, 1), asynchronous, active-low; no other clock.
REQ-006 BAUD_TICK in 1: single-CLK pulse at OVS x baud rate.
REQ-007 RX in 1: serial input, asynchronous to CLK.
REQ-008 PARITY_EN in 1, ODD_N_EVEN in 1, STOP2 in 1: static frame configuration; 1 = parity on / odd parity / two stop bits.
REQ-009 RD_EN in 1: pop the FIFO head.
REQ-010 RD_VALID out 1: FIFO not empty.
REQ-011 RD_DATA out DATA_W: FIFO head data.
REQ-012 RD_PERR out 1, RD_FERR out 1: parity and framing error flags stored with the head entry.
REQ-013 FIFO_LEVEL out clog2(FIFO_DEPTH)+1: current occupancy.
REQ-014 THRESH in clog2(FIFO_DEPTH)+1; THRESH_HIT out 1: FIFO_LEVEL >= THRESH, and THRESH != 0.
REQ-015 OVERFLOW out 1, BREAK_DET out 1: sticky status. TIMEOUT out 1: level status.
REQ-016 CLR_ERR in 1: clears OVERFLOW and BREAK_DET.

Function
REQ-017 RX SHALL pass a 2-flop synchroniser whose flops reset to 1; all logic SHALL use the synchronised value.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK_WAIT. All tick counting SHALL advance only on BAUD_TICK.
REQ-019 IDLE->START SHALL occur on a synchronised 1->0 transition of RX.
REQ-020 START SHALL sample RX at tick OVS/2. If RX is high, the FSM returns to IDLE (glitch reject) and no write occurs; if low, it goes to DATA.
REQ-021 Each bit value SHALL be the 2-of-3 majority of samples at ticks OVS/2-1, OVS/2 and OVS/2+1 of that bit.
REQ-022 DATA SHALL shift exactly DATA_W bits, LSB first, then go to PARITY if PARITY_EN=1, else to STOP.
REQ-023 Parity error SHALL be (XOR of data bits XOR parity bit) != ODD_N_EVEN.
REQ-024 STOP SHALL check one stop bit, or two if STOP2=1. Any stop sample of 0 sets the framing flag for the character.
REQ-025 A break is all data bits 0, parity bit 0 (if enabled), and first stop bit 0. On a break, the FSM SHALL set BREAK_DET, write nothing, and enter BREAK_WAIT until RX=1, then IDLE.
REQ-026 A completed non-break character SHALL be pushed, as {ferr, perr, data}, on the CLK cycle after the final stop sample. The FSM then returns to IDLE.
REQ-027 The FIFO SHALL be first-word-fall-through: RD_VALID rises 1 cycle after a push into an empty FIFO, and RD_DATA/RD_PERR/RD_FERR are valid whenever RD_VALID=1.
REQ-028 RD_EN with RD_VALID=0 SHALL be ignored; the level never underflows.
REQ-029 A push while full and without RD_EN SHALL drop the new character, set OVERFLOW, and leave the FIFO contents unchanged.
REQ-030 A push and a pop in the same cycle SHALL both succeed with the level unchanged, including when full.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH; FIFO_LEVEL SHALL range 0..FIFO_DEPTH inclusive.
REQ-032 If CLR_ERR and a new OVERFLOW or BREAK event occur in the same cycle, the flag SHALL be 1 (set wins).
REQ-033 The timeout counter counts bit periods (every OVS ticks) while in IDLE with RD_VALID=1. It SHALL clear on any start detect, pop, or empty FIFO.
REQ-034 TIMEOUT SHALL assert when the counter reaches TIMEOUT_BITS and hold until the counter clears.
REQ-035 A configuration change mid-character is unsupported; the FSM SHALL still return to IDLE within DATA_W+4 bit periods.

Reset
REQ-036 RESET_N low SHALL asynchronously force the following, including mid-character (the partial character is discarded):
- FSM to IDLE, all counters to 0, synchroniser to 1;
- FIFO empty, RD_VALID=0, RD_DATA=0, RD_PERR=0, RD_FERR=0, FIFO_LEVEL=0;
- THRESH_HIT=0, OVERFLOW=0, BREAK_DET=0, TIMEOUT=0.

Structure
REQ-037 Package uart_pkg SHALL hold the rx FSM state enum, the majority-sample tick constants, and the clog2 level-width function.
REQ-038 The FIFO SHALL be sub-module uart_sync_fifo: register-based, width DATA_W+2, depth FIFO_DEPTH, FWFT, level output.

Verification
REQ-039 Setup: DATA_W=8, OVS=16, 8N1. Send 0xA5 -> one push; RD_DATA=0xA5, RD_PERR=0, RD_FERR=0.
REQ-040 Setup: 8-O-1. Send 0x3C with the wrong parity bit -> RD_PERR=1, RD_DATA=0x3C.
REQ-041 Setup: FIFO_DEPTH=4, no reads. Send 5 bytes 0x01..0x05 -> FIFO holds 0x01..0x04, OVERFLOW=1. Then CLR_ERR -> OVERFLOW=0.
REQ-042 Hold RX low for 20 bit periods -> BREAK_DET=1, FIFO_LEVEL=0. FSM stays in BREAK_WAIT until RX goes high.
REQ-043 Apply a 4-tick low glitch on RX -> no push. Separately, assert RESET_N low at data bit 3 -> all outputs at reset values and no push.
REQ-044 Receive 1 byte, then hold RX idle -> TIMEOUT=1 after 32 bit periods; one pop -> TIMEOUT=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver.
// FSM state encoding, vote placement and FIFO level sizing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_e;

  // Distance of the outer vote samples from the bit centre, in ticks.
  localparam int unsigned MAJ_SPREAD = 1;

  function automatic int unsigned mid_tick(input int unsigned ovs);
    return ovs / 2;
  endfunction

  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Register-based first-word-fall-through FIFO with occupancy output.
// A write while full only succeeds when a read frees a slot that cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned W     = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en_i,
  input  logic [W-1:0]            wr_data_i,
  input  logic                    rd_en_i,
  output logic                    rd_valid_o,
  output logic [W-1:0]            rd_data_o,
  output logic                    full_o,
  output logic [lvl_w(DEPTH)-1:0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = lvl_w(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [LW-1:0] cnt_q;
  logic [LW-1:0] cnt_d;
  logic          push;
  logic          pop;

  assign rd_valid_o = (cnt_q != '0);
  assign full_o     = (cnt_q == LW'(DEPTH));
  assign pop        = rd_en_i & rd_valid_o;
  assign push       = wr_en_i & (~full_o | pop);
  assign level_o    = cnt_q;
  assign rd_data_o  = rd_valid_o ? mem_q[rp_q] : '0;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_rx_gen2.sv
// Oversampling UART receiver with majority vote, break detect,
// RX FIFO, threshold, overflow and idle-timeout status.
module uart_rx_gen2
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned OVS          = 16,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic                         BAUD_TICK,
  input  logic                         RX,
  input  logic                         PARITY_EN,
  input  logic                         ODD_N_EVEN,
  input  logic                         STOP2,
  input  logic                         RD_EN,
  output logic                         RD_VALID,
  output logic [DATA_W-1:0]            RD_DATA,
  output logic                         RD_PERR,
  output logic                         RD_FERR,
  output logic [lvl_w(FIFO_DEPTH)-1:0] FIFO_LEVEL,
  input  logic [lvl_w(FIFO_DEPTH)-1:0] THRESH,
  output logic                         THRESH_HIT,
  output logic                         OVERFLOW,
  output logic                         BREAK_DET,
  output logic                         TIMEOUT,
  input  logic                         CLR_ERR
);

  localparam int unsigned LW = lvl_w(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(OVS);
  localparam int unsigned BW = $clog2(DATA_W + 1);
  localparam int unsigned OW = $clog2(TIMEOUT_BITS + 1);

  localparam logic [TW-1:0] T_LO  = TW'(mid_tick(OVS) - MAJ_SPREAD);
  localparam logic [TW-1:0] T_MID = TW'(mid_tick(OVS));
  localparam logic [TW-1:0] T_HI  = TW'(mid_tick(OVS) + MAJ_SPREAD);
  localparam logic [TW-1:0] T_END = TW'(OVS - 1);
  localparam logic [BW-1:0] B_END = BW'(DATA_W);
  localparam logic [OW-1:0] O_MAX = OW'(TIMEOUT_BITS);

  rx_state_e          state_q;
  rx_state_e          state_d;
  logic               rx_s1_q;
  logic               rx_s2_q;
  logic               rx_d1_q;
  logic [TW-1:0]      tick_q;
  logic [BW-1:0]      bit_q;
  logic [DATA_W-1:0]  sh_q;
  logic               par_q;
  logic               ferr_q;
  logic               stop_q;
  logic [1:0]         samp_q;
  logic               wr_q;
  logic [DATA_W+1:0]  wr_data_q;
  logic               ovf_q;
  logic               brk_q;
  logic [OW-1:0]      to_q;

  logic               rx_s;
  logic               start_det;
  logic               tk_mid;
  logic               tk_hi;
  logic               tk_end;
  logic               maj;
  logic               is_brk;
  logic               stop_last;
  logic               perr;
  logic               pop;
  logic               full;
  logic               ovf_set;
  logic [DATA_W+1:0]  rd_word;

  logic               shift_en;
  logic               par_cap;
  logic               stop_smp;
  logic               push_set;
  logic               brk_set;
  logic               in_idle;

  assign rx_s      = rx_s2_q;
  assign start_det = (state_q == IDLE) & rx_d1_q & ~rx_s;
  assign tk_mid    = BAUD_TICK & (tick_q == T_MID);
  assign tk_hi     = BAUD_TICK & (tick_q == T_HI);
  assign tk_end    = BAUD_TICK & (tick_q == T_END);
  assign maj       = maj3(samp_q[0], samp_q[1], rx_s);
  assign stop_last = ~STOP2 | stop_q;
  assign perr      = PARITY_EN & ((^sh_q ^ par_q) != ODD_N_EVEN);

  // Break: all-zero data, zero parity (if any), zero first stop.
  assign is_brk = ~stop_q & ~maj & (sh_q == '0)
                & ~(PARITY_EN & par_q);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_det) state_d = START;
      end
      START: begin
        if (tk_mid & rx_s) state_d = IDLE;
        else if (tk_end)   state_d = DATA;
      end
      DATA: begin
        if (tk_end & (bit_q == B_END))
          state_d = PARITY_EN ? PARITY : STOP;
      end
      PARITY: begin
        if (tk_end) state_d = STOP;
      end
      STOP: begin
        if (tk_hi) begin
          if (is_brk)         state_d = BREAK_WAIT;
          else if (stop_last) state_d = IDLE;
        end
      end
      BREAK_WAIT: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_en = 1'b0;
    par_cap  = 1'b0;
    stop_smp = 1'b0;
    push_set = 1'b0;
    brk_set  = 1'b0;
    in_idle  = 1'b0;
    unique case (state_q)
      IDLE:   in_idle  = 1'b1;
      DATA:   shift_en = tk_hi;
      PARITY: par_cap  = tk_hi;
      STOP: begin
        stop_smp = tk_hi & ~is_brk;
        push_set = tk_hi & ~is_brk & stop_last;
        brk_set  = tk_hi & is_brk;
      end
      default: in_idle = 1'b0;
    endcase
  end

  assign pop     = RD_EN & RD_VALID;
  assign ovf_set = wr_q & full & ~pop;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_d1_q   <= 1'b1;
      tick_q    <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      par_q     <= 1'b0;
      ferr_q    <= 1'b0;
      stop_q    <= 1'b0;
      samp_q    <= '0;
      wr_q      <= 1'b0;
      wr_data_q <= '0;
      ovf_q     <= 1'b0;
      brk_q     <= 1'b0;
      to_q      <= '0;
    end else begin
      rx_s1_q <= RX;
      rx_s2_q <= rx_s1_q;
      rx_d1_q <= rx_s2_q;

      if (start_det)      tick_q <= '0;
      else if (BAUD_TICK) tick_q <= tk_end ? '0 : tick_q + 1'b1;

      if (BAUD_TICK & (tick_q == T_LO)) samp_q[0] <= rx_s;
      if (tk_mid)                       samp_q[1] <= rx_s;

      if (start_det) begin
        bit_q  <= '0;
        stop_q <= 1'b0;
        ferr_q <= 1'b0;
      end else begin
        if (shift_en) bit_q <= bit_q + 1'b1;
        if (stop_smp) begin
          ferr_q <= ferr_q | ~maj;
          stop_q <= 1'b1;
        end
      end

      if (shift_en) sh_q  <= {maj, sh_q[DATA_W-1:1]};
      if (par_cap)  par_q <= maj;

      wr_q <= push_set;
      if (push_set) wr_data_q <= {ferr_q | ~maj, perr, sh_q};

      ovf_q <= ovf_set | (ovf_q & ~CLR_ERR);
      brk_q <= brk_set | (brk_q & ~CLR_ERR);

      if (start_det | pop | ~RD_VALID)
        to_q <= '0;
      else if (in_idle & tk_end & (to_q != O_MAX))
        to_q <= to_q + 1'b1;
    end
  end

  uart_sync_fifo #(
    .W     (DATA_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .wr_en_i    (wr_q),
    .wr_data_i  (wr_data_q),
    .rd_en_i    (RD_EN),
    .rd_valid_o (RD_VALID),
    .rd_data_o  (rd_word),
    .full_o     (full),
    .level_o    (FIFO_LEVEL)
  );

  assign {RD_FERR, RD_PERR, RD_DATA} = rd_word;

  assign THRESH_HIT = (THRESH != '0) & (FIFO_LEVEL >= THRESH);
  assign OVERFLOW   = ovf_q;
  assign BREAK_DET  = brk_q;
  assign TIMEOUT    = (to_q == O_MAX);

endmodule
